// File: rtl/dm_cache_ctrl.sv
// Controller for a direct-mapped, write-back, write-allocate data cache.
// It sequences the hit check, the dirty victim write-back and the line refill against main memory.
module dm_cache_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req_valid,
  input  logic         cpu_req_rw,
  input  logic [31:0]  cpu_req_addr,
  input  logic [31:0]  cpu_req_data,
  output logic         cpu_req_ready,
  output logic [31:0]  cpu_res_data,
  output logic         cpu_res_ready,
  output logic [9:0]   tag_index,
  output logic         tag_we,
  output logic [19:0]  tag_wdata,
  input  logic [19:0]  tag_rdata,
  output logic [9:0]   data_index,
  output logic         data_we,
  output logic [127:0] data_wdata,
  input  logic [127:0] data_rdata,
  output logic         mem_req_valid,
  output logic         mem_req_rw,
  output logic [31:0]  mem_req_addr,
  output logic [127:0] mem_req_data,
  input  logic         mem_ready,
  input  logic [127:0] mem_data
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t        state;
  state_t        state_next;
  logic          req_rw;
  logic [31:2]   req_addr;
  logic [31:0]   req_data;
  logic [17:0]   vic_tag;
  logic [127:0]  vic_line;

  logic [9:0]    index;
  logic [17:0]   req_tag;
  logic [6:0]    word_off;
  logic          hit;
  logic          unused_addr_bits;

  // The byte offset never matters for word-sized accesses.
  assign unused_addr_bits = ^cpu_req_addr[1:0];

  assign index      = req_addr[13:4];
  assign req_tag    = req_addr[31:14];
  assign word_off   = {req_addr[3:2], 5'b0};
  assign hit        = tag_rdata[19] && (tag_rdata[17:0] == req_tag);
  assign tag_index  = index;
  assign data_index = index;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_rw   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      vic_tag  <= '0;
      vic_line <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && cpu_req_valid) begin
        req_rw   <= cpu_req_rw;
        req_addr <= cpu_req_addr[31:2];
        req_data <= cpu_req_data;
      end
      // The victim must be captured before the refill overwrites the entry.
      if (state == COMPARE && !hit) begin
        vic_tag  <= tag_rdata[17:0];
        vic_line <= data_rdata;
      end
    end
  end

  always_comb begin
    state_next    = state;
    cpu_req_ready = 1'b0;
    cpu_res_data  = '0;
    cpu_res_ready = 1'b0;
    tag_we        = 1'b0;
    tag_wdata     = '0;
    data_we       = 1'b0;
    data_wdata    = '0;
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;

    case (state)
      IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_res_ready = 1'b1;
          state_next    = IDLE;
          if (req_rw) begin
            data_we                   = 1'b1;
            data_wdata                = data_rdata;
            data_wdata[word_off +: 32] = req_data;
            tag_we                    = 1'b1;
            tag_wdata                 = {2'b11, req_tag};
          end else begin
            cpu_res_data = data_rdata[word_off +: 32];
          end
        end else if (tag_rdata[19] && tag_rdata[18]) begin
          state_next = WRITE_BACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b1;
        mem_req_addr  = {vic_tag, index, 4'h0};
        mem_req_data  = vic_line;
        if (mem_ready) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr[31:4], 4'h0};
        if (mem_ready) begin
          data_we    = 1'b1;
          data_wdata = mem_data;
          tag_we     = 1'b1;
          tag_wdata  = {2'b10, req_tag};
          state_next = COMPARE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A reset cycle must never disturb the arrays, even mid-refill.
    if (rst) begin
      tag_we  = 1'b0;
      data_we = 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: models the tag/data arrays and main memory,
// and predicts every transaction from an abstract cache model.
module tb_dm_cache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_valid, cpu_req_rw;
  logic [31:0]  cpu_req_addr, cpu_req_data;
  logic         cpu_req_ready;
  logic [31:0]  cpu_res_data;
  logic         cpu_res_ready;
  logic [9:0]   tag_index, data_index;
  logic         tag_we, data_we;
  logic [19:0]  tag_wdata, tag_rdata;
  logic [127:0] data_wdata, data_rdata;
  logic         mem_req_valid, mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_ready;
  logic [127:0] mem_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_rw(cpu_req_rw),
    .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
    .cpu_req_ready(cpu_req_ready), .cpu_res_data(cpu_res_data), .cpu_res_ready(cpu_res_ready),
    .tag_index(tag_index), .tag_we(tag_we), .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .data_index(data_index), .data_we(data_we), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_ready(mem_ready), .mem_data(mem_data)
  );

  // Cache arrays with asynchronous read and posedge write.
  logic [19:0]  tag_arr  [1024];
  logic [127:0] data_arr [1024];
  logic         arr_clear;

  assign tag_rdata  = tag_arr[tag_index];
  assign data_rdata = data_arr[data_index];

  always @(posedge clk) begin
    if (arr_clear) begin
      for (int i = 0; i < 1024; i++) begin
        tag_arr[i]  <= '0;
        data_arr[i] <= '0;
      end
    end else begin
      if (tag_we)  tag_arr[tag_index]   <= tag_wdata;
      if (data_we) data_arr[data_index] <= data_wdata;
    end
  end

  // Main memory seen by the DUT, and the independent copy the reference model uses.
  logic [127:0] phys_mem [logic [31:0]];
  logic [127:0] ref_mem  [logic [31:0]];

  // Abstract cache contents predicted by the reference model.
  bit         m_valid [1024];
  bit         m_dirty [1024];
  bit [17:0]  m_tag   [1024];
  bit [127:0] m_line  [1024];

  typedef struct {
    bit           wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    bit           alloc;
    logic [31:0]  alloc_addr;
    logic [31:0]  rdata;
    int           latency;
    logic [19:0]  tag_entry;
    logic [127:0] line;
  } exp_t;

  typedef struct {
    int           n_wb;
    logic [31:0]  wb_addr;
    logic [127:0] wb_data;
    int           n_alloc;
    logic [31:0]  alloc_addr;
    bit           res_seen;
    logic [31:0]  rdata;
    int           latency;
    bit           stable;
    logic         ready_at_accept;
  } obs_t;

  function automatic logic [127:0] pattern(input logic [31:0] a);
    return {a ^ 32'h5A5A_1234, a + 32'h0101_0101, ~a, a * 32'd7};
  endfunction

  function automatic logic [127:0] phys_read(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : pattern(a);
  endfunction

  function automatic logic [127:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : pattern(a);
  endfunction

  // Reference model: one whole request resolved from the cache rules, with expected timing.
  task automatic predict(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                         input int wb_wait, input int al_wait, output exp_t e);
    int idx = int'(addr[13:4]);
    int w   = int'(addr[3:2]);
    bit [17:0] tg = addr[31:14];
    e = '{default: 0};
    e.latency = 1;
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e.wb      = 1;
        e.wb_addr = {m_tag[idx], addr[13:4], 4'h0};
        e.wb_data = m_line[idx];
        ref_mem[e.wb_addr] = m_line[idx];
        e.latency += wb_wait + 1;
      end
      e.alloc      = 1;
      e.alloc_addr = {addr[31:4], 4'h0};
      m_line[idx]  = ref_read(e.alloc_addr);
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
      e.latency += al_wait + 2;
    end
    if (rw) begin
      m_line[idx][w*32 +: 32] = data;
      m_dirty[idx] = 1;
    end else begin
      e.rdata = m_line[idx][w*32 +: 32];
    end
    e.tag_entry = {m_valid[idx], m_dirty[idx], m_tag[idx]};
    e.line      = m_line[idx];
  endtask

  // Drives one CPU request, plays main memory with the given stall counts, records what happened.
  task automatic run_req(input bit rw, input logic [31:0] addr, input logic [31:0] data,
                         input int wb_wait, input int al_wait, output obs_t o);
    int cyc = 1;
    int waitc = 0;
    bit in_mem = 0;
    logic [31:0]  f_addr;
    logic         f_rw;
    logic [127:0] f_data;
    o = '{default: 0};
    o.stable = 1;
    o.latency = -1;
    @(negedge clk);
    o.ready_at_accept = cpu_req_ready;
    cpu_req_valid = 1'b1;
    cpu_req_rw    = rw;
    cpu_req_addr  = addr;
    cpu_req_data  = data;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_req_rw    = 1'($urandom);
    cpu_req_addr  = $urandom;
    cpu_req_data  = $urandom;
    while (cyc < 200) begin
      if (cpu_res_ready) begin
        o.res_seen = 1;
        o.rdata    = cpu_res_data;
        o.latency  = cyc;
        break;
      end
      if (mem_req_valid) begin
        if (!in_mem) begin
          in_mem = 1;
          waitc  = 0;
          f_addr = mem_req_addr;
          f_rw   = mem_req_rw;
          f_data = mem_req_data;
          if (mem_req_rw) begin
            o.n_wb++;
            o.wb_addr = mem_req_addr;
            o.wb_data = mem_req_data;
          end else begin
            o.n_alloc++;
            o.alloc_addr = mem_req_addr;
          end
        end else if (mem_req_addr !== f_addr || mem_req_rw !== f_rw ||
                     (f_rw && mem_req_data !== f_data)) begin
          o.stable = 0;
        end
        if (waitc == (mem_req_rw ? wb_wait : al_wait)) begin
          mem_ready = 1'b1;
          if (mem_req_rw) phys_mem[mem_req_addr] = mem_req_data;
          else            mem_data = phys_read(mem_req_addr);
          in_mem = 0;
        end else begin
          waitc++;
          mem_data = {$urandom, $urandom, $urandom, $urandom};
        end
      end else begin
        // Stray completion pulses outside memory states must be ignored.
        mem_ready = 1'($urandom);
        mem_data  = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      mem_ready = 1'b0;
      cyc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    arr_clear = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_rw = 1'b0; cpu_req_addr = '0; cpu_req_data = '0;
    mem_ready = 1'b0; mem_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", cpu_req_ready); end
    checks++; if (cpu_res_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_ready: got %b expected 0", cpu_res_ready); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_valid: got %b expected 0", mem_req_valid); end
    checks++; if ({tag_we, data_we} !== 2'b00) begin errors++; $display("[TB] FAIL reset_we: got %b expected 00", {tag_we, data_we}); end
    checks++; if (tag_index !== 10'd0 || mem_req_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_index_addr: got %h/%h expected 0/0", tag_index, mem_req_addr); end
    rst = 1'b0;
    arr_clear = 1'b0;
  endtask

  task automatic test_clean_miss();
    exp_t e; obs_t o;
    predict(0, 32'h0000_1234, 0, 0, 2, e);
    run_req(0, 32'h0000_1234, 0, 0, 2, o);
    checks++; if (o.ready_at_accept !== 1'b1) begin errors++; $display("[TB] FAIL miss_req_ready: got %b expected 1", o.ready_at_accept); end
    checks++; if (o.n_alloc != 1 || o.n_wb != 0) begin errors++; $display("[TB] FAIL miss_mem_count: got alloc=%0d wb=%0d expected 1/0", o.n_alloc, o.n_wb); end
    checks++; if (o.alloc_addr !== 32'h0000_1230) begin errors++; $display("[TB] FAIL miss_alloc_addr: got %h expected 00001230", o.alloc_addr); end
    checks++; if (o.rdata !== 32'hBBBB_BBBB) begin errors++; $display("[TB] FAIL miss_rdata: got %h expected bbbbbbbb", o.rdata); end
    checks++; if (o.latency != 5) begin errors++; $display("[TB] FAIL miss_latency: got %0d expected 5", o.latency); end
    checks++; if (tag_arr[10'h123] !== 20'h80000) begin errors++; $display("[TB] FAIL miss_tag: got %h expected 80000", tag_arr[10'h123]); end
  endtask

  task automatic test_read_hit();
    exp_t e; obs_t o;
    predict(0, 32'h0000_1234, 0, 0, 0, e);
    run_req(0, 32'h0000_1234, 0, 0, 0, o);
    checks++; if (o.latency != 1) begin errors++; $display("[TB] FAIL hit_latency: got %0d expected 1", o.latency); end
    checks++; if (o.n_alloc + o.n_wb != 0) begin errors++; $display("[TB] FAIL hit_no_mem: got %0d requests expected 0", o.n_alloc + o.n_wb); end
    checks++; if (o.rdata !== 32'hBBBB_BBBB) begin errors++; $display("[TB] FAIL hit_rdata: got %h expected bbbbbbbb", o.rdata); end
  endtask

  task automatic test_write_hit();
    exp_t e; obs_t o;
    predict(1, 32'h0000_1238, 32'hCAFE_F00D, 0, 0, e);
    run_req(1, 32'h0000_1238, 32'hCAFE_F00D, 0, 0, o);
    checks++; if (o.latency != 1) begin errors++; $display("[TB] FAIL whit_latency: got %0d expected 1", o.latency); end
    checks++; if (tag_arr[10'h123] !== 20'hC0000) begin errors++; $display("[TB] FAIL whit_tag: got %h expected c0000", tag_arr[10'h123]); end
    checks++; if (data_arr[10'h123] !== 128'hDDDDDDDD_CAFEF00D_BBBBBBBB_AAAAAAAA) begin errors++; $display("[TB] FAIL whit_line: got %h expected ddddddddcafef00dbbbbbbbbaaaaaaaa", data_arr[10'h123]); end
  endtask

  task automatic test_dirty_miss();
    exp_t e; obs_t o;
    predict(0, 32'h0000_5234, 0, 1, 0, e);
    run_req(0, 32'h0000_5234, 0, 1, 0, o);
    checks++; if (o.n_wb != 1 || o.wb_addr !== 32'h0000_1230) begin errors++; $display("[TB] FAIL dirty_wb_addr: got n=%0d %h expected 1 00001230", o.n_wb, o.wb_addr); end
    checks++; if (o.wb_data !== 128'hDDDDDDDD_CAFEF00D_BBBBBBBB_AAAAAAAA) begin errors++; $display("[TB] FAIL dirty_wb_data: got %h expected ddddddddcafef00dbbbbbbbbaaaaaaaa", o.wb_data); end
    checks++; if (o.n_alloc != 1 || o.alloc_addr !== 32'h0000_5230) begin errors++; $display("[TB] FAIL dirty_alloc_addr: got n=%0d %h expected 1 00005230", o.n_alloc, o.alloc_addr); end
    checks++; if (tag_arr[10'h123] !== 20'h80001) begin errors++; $display("[TB] FAIL dirty_tag: got %h expected 80001", tag_arr[10'h123]); end
    checks++; if (o.rdata !== e.rdata || o.latency != e.latency) begin errors++; $display("[TB] FAIL dirty_result: got %h/%0d expected %h/%0d", o.rdata, o.latency, e.rdata, e.latency); end
  endtask

  task automatic test_mem_stall();
    exp_t e; obs_t o;
    predict(0, 32'h0009_0048, 0, 0, 5, e);
    run_req(0, 32'h0009_0048, 0, 0, 5, o);
    checks++; if (o.stable !== 1'b1) begin errors++; $display("[TB] FAIL stall_stable: got %b expected 1", o.stable); end
    checks++; if (o.latency != 8) begin errors++; $display("[TB] FAIL stall_latency: got %0d expected 8", o.latency); end
    checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL stall_rdata: got %h expected %h", o.rdata, e.rdata); end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o;
    int n;
    // Make line 0x1230 resident and dirty so the next conflicting read must write back.
    predict(1, 32'h0000_1234, 32'h1357_9BDF, 0, 0, e);
    run_req(1, 32'h0000_1234, 32'h1357_9BDF, 0, 0, o);
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0000_5234;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_req_valid && mem_req_rw) && n < 20) begin @(negedge clk); n++; end
    checks++; if (!(mem_req_valid && mem_req_rw)) begin errors++; $display("[TB] FAIL rstwb_reach: got valid=%b rw=%b expected 1/1", mem_req_valid, mem_req_rw); end
    rst = 1'b1;
    #1;
    checks++; if ({tag_we, data_we} !== 2'b00) begin errors++; $display("[TB] FAIL rstwb_we: got %b expected 00", {tag_we, data_we}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rstwb_idle: got valid=%b ready=%b expected 0/1", mem_req_valid, cpu_req_ready); end
    predict(0, 32'h0000_1234, 0, 0, 0, e);
    run_req(0, 32'h0000_1234, 0, 0, 0, o);
    checks++; if (o.latency != 1 || o.rdata !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL rstwb_rehit: got %0d/%h expected 1/13579bdf", o.latency, o.rdata); end

    // Reset landing on the very cycle a refill completes must not write the arrays.
    @(negedge clk);
    cpu_req_valid = 1'b1; cpu_req_rw = 1'b0; cpu_req_addr = 32'h0001_0050;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    n = 0;
    while (!(mem_req_valid && !mem_req_rw) && n < 20) begin @(negedge clk); n++; end
    checks++; if (!(mem_req_valid && !mem_req_rw)) begin errors++; $display("[TB] FAIL rstal_reach: got valid=%b rw=%b expected 1/0", mem_req_valid, mem_req_rw); end
    rst = 1'b1; mem_ready = 1'b1; mem_data = {4{32'hFEED_0001}};
    #1;
    checks++; if ({tag_we, data_we} !== 2'b00) begin errors++; $display("[TB] FAIL rstal_we: got %b expected 00", {tag_we, data_we}); end
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstal_valid: got %b expected 0", mem_req_valid); end
    checks++; if (tag_arr[10'h005] !== {m_valid[5], m_dirty[5], m_tag[5]}) begin errors++; $display("[TB] FAIL rstal_tag: got %h expected %h", tag_arr[10'h005], {m_valid[5], m_dirty[5], m_tag[5]}); end
  endtask

  task automatic test_random();
    exp_t e; obs_t o;
    logic [9:0] idx;
    logic [31:0] addr, data;
    bit rw;
    int ww, aw;
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 3))
        0: idx = 10'h123;
        1: idx = 10'h005;
        2: idx = 10'h3FF;
        default: idx = 10'($urandom_range(0, 1023));
      endcase
      addr = {18'($urandom_range(0, 3)), idx, 2'($urandom), 2'($urandom)};
      data = $urandom;
      rw   = 1'($urandom);
      ww   = $urandom_range(0, 3);
      aw   = $urandom_range(0, 3);
      predict(rw, addr, data, ww, aw, e);
      run_req(rw, addr, data, ww, aw, o);
      checks++; if (!o.res_seen || o.latency != e.latency) begin errors++; $display("[TB] FAIL rnd_latency t=%0d: got %0d expected %0d", t, o.latency, e.latency); end
      checks++; if (o.n_wb != int'(e.wb) || (e.wb && (o.wb_addr !== e.wb_addr || o.wb_data !== e.wb_data))) begin errors++; $display("[TB] FAIL rnd_wb t=%0d: got n=%0d %h %h expected n=%0d %h %h", t, o.n_wb, o.wb_addr, o.wb_data, e.wb, e.wb_addr, e.wb_data); end
      checks++; if (o.n_alloc != int'(e.alloc) || (e.alloc && o.alloc_addr !== e.alloc_addr)) begin errors++; $display("[TB] FAIL rnd_alloc t=%0d: got n=%0d %h expected n=%0d %h", t, o.n_alloc, o.alloc_addr, e.alloc, e.alloc_addr); end
      checks++; if (!o.stable) begin errors++; $display("[TB] FAIL rnd_stable t=%0d: got 0 expected 1", t); end
      if (!rw) begin
        checks++; if (o.rdata !== e.rdata) begin errors++; $display("[TB] FAIL rnd_rdata t=%0d: got %h expected %h", t, o.rdata, e.rdata); end
      end
      checks++; if (tag_arr[idx] !== e.tag_entry || data_arr[idx] !== e.line) begin errors++; $display("[TB] FAIL rnd_array t=%0d: got %h %h expected %h %h", t, tag_arr[idx], data_arr[idx], e.tag_entry, e.line); end
    end
  endtask

  initial begin
    phys_mem[32'h0000_1230] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    ref_mem[32'h0000_1230]  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    $display("[TB] starting dm_cache_ctrl bench");
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_mem_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Controller state machine for the direct-mapped, write-back, write-allocate data cache. It sits between the CPU load/store port and the cache arrays. It drives index and write-enable commands into the 1024-entry tag memory and the matching data memory, and uses their asynchronous read ports for the hit check. Misses are resolved through a valid/ready handshake to main memory: dirty victim write-back first, then line refill.

## Interface
- Parameters: none. Fixed geometry:
  - address 32 b: tag = addr[31:14] (18 b), index = addr[13:4] (10 b), word = addr[3:2]
  - line 128 b (4 × 32-b words)
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- cpu_req_valid  in  1  CPU request strobe
- cpu_req_rw  in  1  1 = write, 0 = read
- cpu_req_addr  in  32  byte address; bits [1:0] ignored
- cpu_req_data  in  32  store data
- cpu_req_ready  out  1  high only in IDLE; request accepted when valid && ready
- cpu_res_data  out  32  load data; meaningful only while cpu_res_ready = 1
- cpu_res_ready  out  1  one-cycle completion pulse
- tag_index  out  10  tag array index
- tag_we  out  1  tag array write enable
- tag_wdata  out  20  {valid, dirty, tag[17:0]}
- tag_rdata  in  20  asynchronous tag read, same layout as tag_wdata
- data_index  out  10  data array index; always equals tag_index
- data_we  out  1  data array write enable
- data_wdata  out  128  data array write line
- data_rdata  in  128  asynchronous data read
- mem_req_valid  out  1  memory request strobe
- mem_req_rw  out  1  1 = write-back, 0 = refill
- mem_req_addr  out  32  line-aligned address; [3:0] = 0
- mem_req_data  out  128  write-back line
- mem_ready  in  1  memory completion pulse; carries mem_data
- mem_data  in  128  refill line

## Operation
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE.
- Latched request registers: req_rw, req_addr, req_data.
- Victim registers: vic_tag, vic_line.
- tag_index = req_addr[13:4] in every state.
- **IDLE**
  - On valid && ready: latch the request, go to COMPARE.
  - Otherwise stay in IDLE.
- **COMPARE**
  - hit = tag_rdata[19] && (tag_rdata[17:0] == req_addr[31:14]).
  - Read hit:
    - cpu_res_data = data_rdata word selected by req_addr[3:2]
    - cpu_res_ready = 1; go to IDLE.
  - Write hit:
    - data_we = 1; data_wdata = data_rdata with word req_addr[3:2] replaced by req_data.
    - tag_we = 1; tag_wdata = {1, 1, tag}.
    - cpu_res_ready = 1; go to IDLE.
  - Miss:
    - Capture vic_tag = tag_rdata[17:0] and vic_line = data_rdata.
    - If the victim is valid && dirty, go to WRITE_BACK; else go to ALLOCATE.
    - No array write on a miss.
- **WRITE_BACK**
  - mem_req_valid = 1, mem_req_rw = 1.
  - mem_req_addr = {vic_tag, index, 4'h0}; mem_req_data = vic_line.
  - On mem_ready, go to ALLOCATE.
- **ALLOCATE**
  - mem_req_valid = 1, mem_req_rw = 0, mem_req_addr = {req_addr[31:4], 4'h0}.
  - On mem_ready:
    - data_we = 1, data_wdata = mem_data.
    - tag_we = 1, tag_wdata = {1, 0, req tag}.
    - Go to COMPARE; the retry then hits.
- All mem_req_* outputs stay stable while mem_req_valid = 1 and mem_ready = 0.
- mem_ready is ignored outside WRITE_BACK and ALLOCATE.
- cpu_req_valid is ignored outside IDLE.

## Timing
- Reset values:
  - state = IDLE
  - cpu_req_ready = 1 (follows IDLE); every other output = 0
  - latched and victim registers = 0
- Outputs are combinational decodes of state, latched registers and array read data.
- Hit latency: cpu_res_ready is high in the cycle immediately after acceptance, i.e. 1 cycle.
- Clean miss: accept → COMPARE (1) → ALLOCATE (≥1, until mem_ready) → COMPARE hit. Total = 3 + memory wait cycles.
- Dirty miss: adds the WRITE_BACK cycles before ALLOCATE.
- The earliest next accept is the cycle after the cpu_res_ready pulse, which falls in IDLE.
- mem_ready sampled high in the first cycle of a memory state completes that state in 1 cycle.
- Reset mid-operation:
  - Next cycle is IDLE; any outstanding mem_req_valid drops and the request is abandoned.
  - Array contents are untouched, since rst gates tag_we and data_we to 0 in the reset cycle.
  - A refill in flight is discarded.
- Array writes take effect at the posedge ending the cycle in which tag_we / data_we is high. The COMPARE that follows ALLOCATE sees the new tag.

## Test plan
1. Reset, then read 0x0000_1234 with the array invalid:
   - one ALLOCATE request, addr 0x0000_1230, rw 0
   - mem_data = 0xDDDD…_CCCC_BBBB_AAAA → cpu_res_data = 0xBBBB_xxxx word 1; tag index 0x123 written {1, 0, 0x00000}
2. Repeat the read of 0x0000_1234 → cpu_res_ready high exactly 1 cycle after acceptance, no mem_req_valid.
3. Write 0xCAFE_F00D to 0x0000_1238 → word 2 replaced; tag written {1, 1, 0}; completes in 1 cycle.
4. Read 0x0000_5234 (same index 0x123, tag 1):
   - WRITE_BACK at 0x0000_1230 carrying the modified line
   - then ALLOCATE at 0x0000_5230
   - final tag {1, 0, 0x00001}
5. Hold mem_ready low for 5 cycles in ALLOCATE → mem_req_addr / rw / valid stable throughout; completion exactly 1 cycle after mem_ready is sampled.
6. Assert rst during WRITE_BACK → next cycle IDLE, mem_req_valid = 0, no tag_we / data_we; then a read of 0x0000_1234 hits.
